// File: rtl/sram_bank.sv
// Single-port byte-writable SRAM bank with an optional zero-fill sweep after reset.
// Read data comes out registered, after 1 or 2 cycles; rejected accesses pulse SRAMERR instead.
module sram_bank #(
    parameter int unsigned WAW        = 14,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH      = 2 ** WAW,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            SRAMCS,
    input  logic [WAW-1:0]  SRAMADDR,
    input  logic [DW/8-1:0] SRAMWEN,
    input  logic [DW-1:0]   SRAMWDATA,
    output logic [DW-1:0]   SRAMRDATA,
    output logic            SRAMRVALID,
    output logic            SRAMERR,
    output logic            SRAMBUSY
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAW:0] DEPTH_W = (WAW + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {StClear, StReady} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   mem [DEPTH];

    logic            in_range, acc, wr_acc, rd_acc, err_req;
    logic [IW-1:0]   idx;

    logic            v1_q, e1_q;
    logic [DW-1:0]   d1_q;

    // Address is widened by one bit so DEPTH == 2**WAW compares correctly.
    assign in_range = {1'b0, SRAMADDR} < DEPTH_W;
    assign idx      = SRAMADDR[IW-1:0];
    assign acc      = SRAMCS && (state_q == StReady) && in_range;
    assign wr_acc   = acc && (|SRAMWEN);
    assign rd_acc   = acc && !(|SRAMWEN);
    assign err_req  = SRAMCS && !acc;
    assign SRAMBUSY = (state_q == StClear);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            if (cnt_q == LAST_IDX) begin
                state_d = StReady;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= (INIT_CLEAR != 0) ? StClear : StReady;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array has no reset; the sweep (or nothing, if INIT_CLEAR=0) defines contents.
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            if (state_q == StClear) begin
                mem[cnt_q] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (SRAMWEN[i]) mem[idx][8*i +: 8] <= SRAMWDATA[8*i +: 8];
                end
            end
        end
    end

    // Stage 1: array read register. Data only loads on a read so it holds otherwise.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_acc;
            e1_q <= err_req;
            if (rd_acc) d1_q <= mem[idx];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic          v2_q, e2_q;
        logic [DW-1:0] d2_q;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                if (v1_q) d2_q <= d1_q;
            end
        end

        assign SRAMRDATA  = d2_q;
        assign SRAMRVALID = v2_q;
        assign SRAMERR    = e2_q;
    end else begin : g_lat1
        assign SRAMRDATA  = d1_q;
        assign SRAMRVALID = v1_q;
        assign SRAMERR    = e1_q;
    end

endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 Parameter WAW, default 14, word-address width.
REQ-002 Parameter DW, default 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 2**WAW, number of implemented words; SHALL satisfy 1 <= DEPTH <= 2**WAW.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 Parameter INIT_CLEAR, default 1; 1 = zero-fill the array after reset, 0 = no fill.
REQ-006 HCLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-007 HRESET  input  1  reset, synchronous and active-high.
REQ-008 SRAMCS  input  1  access request, valid for one cycle.
REQ-009 SRAMADDR  input  WAW  word address.
REQ-010 SRAMWEN  input  DW/8  byte write enables, active high; all-zero = read.
REQ-011 SRAMWDATA  input  DW  write data, lane i = bits 8i+7:8i.
REQ-012 SRAMRDATA  output  DW  registered read data.
REQ-013 SRAMRVALID  output  1  one-cycle pulse, SRAMRDATA valid.
REQ-014 SRAMERR  output  1  one-cycle pulse, access rejected.
REQ-015 SRAMBUSY  output  1  initialisation sweep in progress; accesses not accepted.

Function
REQ-016 Control FSM SHALL have two states: CLEAR and READY.
REQ-017 Reset SHALL enter CLEAR if INIT_CLEAR=1, else READY.
REQ-018 In CLEAR, a sweep counter SHALL write 0 to word k on cycle k, k = 0..DEPTH-1, then enter READY on the cycle after word DEPTH-1 is written; SRAMBUSY=1 exactly while in CLEAR.
REQ-019 Sweep duration SHALL be DEPTH cycles.
REQ-020 Accepted access = SRAMCS=1 in READY with SRAMADDR < DEPTH.
REQ-021 Accepted write (SRAMWEN != 0) SHALL update only the enabled byte lanes at that edge; other lanes retain their value; no SRAMRVALID.
REQ-022 Accepted read (SRAMWEN = 0) SHALL present mem[SRAMADDR] on SRAMRDATA with SRAMRVALID=1 exactly RD_LAT cycles after the access cycle.
REQ-023 RD_LAT=2 SHALL add one pipeline register after the array; back-to-back reads every cycle SHALL be supported at full throughput for both latencies.
REQ-024 A read issued in the cycle immediately after a write to the same address SHALL return the newly written data.
REQ-025 SRAMRDATA SHALL hold its last value while SRAMRVALID=0 and SHALL never be driven to Z or X after reset.
REQ-026 SRAMCS=1 with SRAMADDR >= DEPTH SHALL modify no memory, SHALL NOT assert SRAMRVALID, and SHALL pulse SRAMERR RD_LAT cycles after the access cycle.
REQ-027 SRAMCS=1 during CLEAR SHALL be ignored, with SRAMERR pulsed RD_LAT cycles later.
REQ-028 SRAMCS=0 SHALL produce no state change except the sweep.
REQ-029 Array contents SHALL be undefined after reset when INIT_CLEAR=0.

Reset
REQ-030 HRESET=1 SHALL set SRAMRDATA=0, SRAMRVALID=0, SRAMERR=0, clear the sweep counter and all pipeline stages at the next edge; SRAMBUSY SHALL follow REQ-017/REQ-018.
REQ-031 HRESET asserted mid-sweep SHALL restart the sweep from word 0.
REQ-032 HRESET asserted with a read in the pipeline SHALL cancel it; no SRAMRVALID for that read.
REQ-033 HRESET SHALL take priority over any simultaneous access.

Verification
REQ-034 DEPTH=16, INIT_CLEAR=1: release reset -> SRAMBUSY high for exactly 16 cycles; then reads of addresses 0..15 return 0.
REQ-035 RD_LAT=1: write 0xDEADBEEF to addr 3, WEN=0xF; next cycle read addr 3 -> SRAMRDATA=0xDEADBEEF with SRAMRVALID on the following cycle.
REQ-036 Write 0x11223344 to addr 5, then WEN=0x2 with data 0xAABBCCDD -> read addr 5 returns 0x1122CC44.
REQ-037 DEPTH=16: write addr 20 with WEN=0xF -> SRAMERR pulses once, memory unchanged; read addr 20 -> no SRAMRVALID, SRAMERR pulse.
REQ-038 RD_LAT=2: reads of addrs 0,1,2 on consecutive cycles -> three consecutive SRAMRVALID pulses starting 2 cycles after the first read, data in order.
REQ-039 Assert HRESET on sweep cycle 7, then release -> SRAMBUSY stays high for a full 16 further cycles; a read pending at reset yields no SRAMRVALID.
